// File: rtl/seg_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_capture : multiplexed seven-segment bus monitor -> BCD and h:m:s  (rev 1.0)
// ----------------------------------------------------------------------------
module seg_capture #(
   parameter int P_SETTLE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   input  logic [5:0]  i_seg_enb,
   output logic [23:0] o_digits,
   output logic [5:0]  o_dp,
   output logic [5:0]  o_sec,
   output logic [5:0]  o_min,
   output logic [5:0]  o_hour,
   output logic        o_frame_valid,
   output logic        o_err
);
   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   localparam logic [7:0] c_settle = 8'(P_SETTLE);

   state_t      r_state, w_state_nxt;
   logic [13:0] r_smp, r_prev;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic        w_cap;
   logic [5:0]  w_enb_n;
   logic        w_onehot, w_same, w_enb_chg;
   logic [2:0]  w_k;

   logic        r_cap_vld;
   logic [2:0]  r_cap_k;
   logic [6:0]  r_cap_seg;
   logic        r_cap_dp;

   logic [2:0]  r_idx;
   logic [23:0] r_stage;
   logic [5:0]  r_stage_dp;
   logic        r_ferr;

   logic [3:0]  w_dec;
   logic        w_dec_err;
   logic [23:0] w_frame;
   logic [3:0]  w_v [6];
   logic [6:0]  w_sec7, w_min7, w_hour7;
   logic        w_bad;

   assign w_enb_n   = ~r_smp[13:8];
   assign w_onehot  = (w_enb_n != 6'd0) && ((w_enb_n & (w_enb_n - 6'd1)) == 6'd0);
   assign w_same    = (r_smp == r_prev);
   assign w_enb_chg = (r_smp[13:8] != r_prev[13:8]);

   always_comb begin
      w_k = 3'd0;
      for (int i = 0; i < 6; i++)
         if (w_enb_n[i]) w_k = 3'(i);
   end

   // r_cnt holds the number of edges smp has been stable, so entry edges count as 1
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cap       = 1'b0;
      case (r_state)
         S_WAIT: begin
            if (w_onehot) begin
               w_state_nxt = S_SETTLE;
               w_cnt_nxt   = 8'd1;
            end
         end
         S_SETTLE: begin
            if (!w_onehot) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt = w_same ? (r_cnt + 8'd1) : 8'd1;
            end
         end
         S_HOLD: begin
            if (w_enb_chg) begin
               w_state_nxt = w_onehot ? S_SETTLE : S_WAIT;
               w_cnt_nxt   = w_onehot ? 8'd1 : 8'd0;
            end
         end
         default: begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 8'd0;
         end
      endcase
      if ((w_state_nxt == S_SETTLE) && (w_cnt_nxt == c_settle)) begin
         w_cap       = 1'b1;
         w_state_nxt = S_HOLD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_smp     <= {6'h3F, 8'h00};
         r_prev    <= {6'h3F, 8'h00};
         r_state   <= S_WAIT;
         r_cnt     <= 8'd0;
         r_cap_vld <= 1'b0;
         r_cap_k   <= 3'd0;
         r_cap_seg <= 7'd0;
         r_cap_dp  <= 1'b0;
      end else begin
         r_smp     <= {i_seg_enb, i_seg, i_seg_dp};
         r_prev    <= r_smp;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cap_vld <= w_cap;
         r_cap_k   <= w_k;
         r_cap_seg <= r_smp[7:1];
         r_cap_dp  <= r_smp[0];
      end
   end

   always_comb begin
      w_dec_err = 1'b0;
      case (r_cap_seg)
         7'h7E:   w_dec = 4'd0;
         7'h30:   w_dec = 4'd1;
         7'h6D:   w_dec = 4'd2;
         7'h79:   w_dec = 4'd3;
         7'h33:   w_dec = 4'd4;
         7'h5B:   w_dec = 4'd5;
         7'h5F:   w_dec = 4'd6;
         7'h70:   w_dec = 4'd7;
         7'h7F:   w_dec = 4'd8;
         7'h73:   w_dec = 4'd9;
         7'h00:   w_dec = 4'hF;
         default: begin
            w_dec     = 4'hE;
            w_dec_err = 1'b1;
         end
      endcase
   end

   // Frame as it would be with the digit-5 capture in flight; blanks count as zero
   assign w_frame = {w_dec, r_stage[19:0]};

   always_comb begin
      w_bad = r_ferr | w_dec_err;
      for (int i = 0; i < 6; i++) begin
         w_v[i] = (w_frame[4*i +: 4] == 4'hF) ? 4'd0 : w_frame[4*i +: 4];
         if (w_v[i] > 4'd9) w_bad = 1'b1;
      end
      w_sec7  = {3'b000, w_v[1]} * 7'd10 + {3'b000, w_v[0]};
      w_min7  = {3'b000, w_v[3]} * 7'd10 + {3'b000, w_v[2]};
      w_hour7 = {3'b000, w_v[5]} * 7'd10 + {3'b000, w_v[4]};
      if ((w_v[1] > 4'd5) || (w_v[3] > 4'd5) || (w_hour7 > 7'd23)) w_bad = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx         <= 3'd0;
         r_stage       <= 24'd0;
         r_stage_dp    <= 6'd0;
         r_ferr        <= 1'b0;
         o_digits      <= 24'hFFFFFF;
         o_dp          <= 6'd0;
         o_sec         <= 6'd0;
         o_min         <= 6'd0;
         o_hour        <= 6'd0;
         o_frame_valid <= 1'b0;
         o_err         <= 1'b0;
      end else begin
         o_frame_valid <= 1'b0;
         o_err         <= 1'b0;
         if (r_cap_vld) begin
            if (r_cap_k == 3'd0) begin
               r_stage[3:0]  <= w_dec;
               r_stage_dp[0] <= r_cap_dp;
               r_ferr        <= w_dec_err;
               r_idx         <= 3'd1;
            end else if (r_idx == 3'd0) begin
               // out of sync: silently wait for digit 0
               r_idx <= 3'd0;
            end else if (r_cap_k != r_idx) begin
               o_err <= 1'b1;
               r_idx <= 3'd0;
            end else if (r_cap_k == 3'd5) begin
               r_idx <= 3'd0;
               if (w_bad) begin
                  o_err <= 1'b1;
               end else begin
                  o_digits      <= w_frame;
                  o_dp          <= {r_cap_dp, r_stage_dp[4:0]};
                  o_sec         <= w_sec7[5:0];
                  o_min         <= w_min7[5:0];
                  o_hour        <= w_hour7[5:0];
                  o_frame_valid <= 1'b1;
               end
            end else begin
               r_stage[{r_cap_k, 2'b00} +: 4] <= w_dec;
               r_stage_dp[r_cap_k]            <= r_cap_dp;
               r_ferr                         <= r_ferr | w_dec_err;
               r_idx                          <= r_idx + 3'd1;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
`timescale 1ns/1ps
// tb_seg_capture : randomized + directed scan stimulus, queue scoreboard against a digit-level model.
module tb_seg_capture;
   localparam int P = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  i_seg = 7'd0;
   logic        i_seg_dp = 1'b0;
   logic [5:0]  i_seg_enb = 6'h3F;
   logic [23:0] o_digits;
   logic [5:0]  o_dp, o_sec, o_min, o_hour;
   logic        o_frame_valid, o_err;

   int checks = 0;
   int failures = 0;

   logic [48:0] sb_q[$];   // {is_err, digits, dp, sec, min, hour}

   int          m_idx;
   int          m_dig[6];
   logic [5:0]  m_dp;
   bit          m_ferr;
   logic [47:0] m_out;

   seg_capture #(.P_SETTLE(P)) dut (
      .clk(clk), .rst_n(rst_n), .i_seg(i_seg), .i_seg_dp(i_seg_dp), .i_seg_enb(i_seg_enb),
      .o_digits(o_digits), .o_dp(o_dp), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
      .o_frame_valid(o_frame_valid), .o_err(o_err)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int seg2bcd(input logic [6:0] s);
      case (s)
         7'h7E: return 0;  7'h30: return 1;  7'h6D: return 2;  7'h79: return 3;
         7'h33: return 4;  7'h5B: return 5;  7'h5F: return 6;  7'h70: return 7;
         7'h7F: return 8;  7'h73: return 9;  7'h00: return 15;
         default: return 14;
      endcase
   endfunction

   function automatic logic [6:0] bcd2seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'h7E; 4'd1: return 7'h30; 4'd2: return 7'h6D; 4'd3: return 7'h79;
         4'd4: return 7'h33; 4'd5: return 7'h5B; 4'd6: return 7'h5F; 4'd7: return 7'h70;
         4'd8: return 7'h7F; 4'd9: return 7'h73;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [41:0] segs_of(input logic [23:0] bcd);
      logic [41:0] s;
      for (int k = 0; k < 6; k++) s[7*k +: 7] = bcd2seg(bcd[4*k +: 4]);
      return s;
   endfunction

   task automatic model_reset();
      m_idx  = 0;
      m_dp   = 6'd0;
      m_ferr = 1'b0;
      for (int i = 0; i < 6; i++) m_dig[i] = 0;
      m_out  = {24'hFFFFFF, 24'd0};
   endtask

   task automatic model_capture(input int k, input logic [6:0] seg, input logic dp, output bit pulse);
      int d;
      int v[6];
      bit ok;
      logic [23:0] digs;
      d = seg2bcd(seg);
      pulse = 1'b0;
      if (k == 0) begin
         m_dig[0] = d; m_dp[0] = dp; m_ferr = (d == 14); m_idx = 1;
      end else if (m_idx == 0) begin
         m_idx = 0;
      end else if (k != m_idx) begin
         sb_q.push_back({1'b1, m_out});
         m_idx = 0;
         pulse = 1'b1;
      end else begin
         m_dig[k] = d; m_dp[k] = dp;
         if (d == 14) m_ferr = 1'b1;
         if (k < 5) m_idx++;
         else begin
            m_idx = 0;
            pulse = 1'b1;
            ok = !m_ferr;
            for (int i = 0; i < 6; i++) begin
               v[i] = (m_dig[i] == 15) ? 0 : m_dig[i];
               if (v[i] > 9) ok = 1'b0;
               digs[4*i +: 4] = 4'(m_dig[i]);
            end
            if (v[1] > 5 || v[3] > 5 || v[5]*10 + v[4] > 23) ok = 1'b0;
            if (ok) begin
               m_out = {digs, m_dp, 6'(v[1]*10 + v[0]), 6'(v[3]*10 + v[2]), 6'(v[5]*10 + v[4])};
               sb_q.push_back({1'b0, m_out});
            end else begin
               sb_q.push_back({1'b1, m_out});
            end
         end
      end
   endtask

   // One enable period for digit k; any frame-end/sequence pulse must land P+2 edges after the switch.
   task automatic period(input int k, input logic [6:0] seg, input logic dp, input int hold, input bit glitch);
      bit pulse;
      int first;
      int gap;
      logic [6:0] gl;
      model_capture(k, seg, dp, pulse);
      gl = (seg == 7'h7E) ? 7'h30 : 7'h7E;
      first = -1;
      i_seg_enb = ~(6'd1 << k);
      i_seg_dp  = dp;
      for (int c = 1; c <= hold; c++) begin
         i_seg = (glitch && (c == 3 || c == 4)) ? gl : seg;
         @(posedge clk); #1;
         if ((o_frame_valid || o_err) && first < 0) first = c;
      end
      chk($sformatf("pulse_latency_k%0d", k), 64'(first), pulse ? 64'(P + 2) : 64'(-1));
      gap = $urandom_range(0, 2);
      i_seg_enb = 6'h3F;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_frame(input logic [41:0] segs, input logic [5:0] dps, input int hold,
                             input bit glitch0, input int skip);
      for (int k = 0; k < 6; k++)
         if (k != skip) period(k, segs[7*k +: 7], dps[k], hold, glitch0 && (k == 0));
   endtask

   task automatic rand_frame();
      int h, m, s, skip, hold;
      logic [23:0] bcd;
      logic [41:0] segs;
      logic [6:0] bad[4];
      bad[0] = 7'h01; bad[1] = 7'h08; bad[2] = 7'h49; bad[3] = 7'h0F;
      h = $urandom_range(0, 27); m = $urandom_range(0, 65); s = $urandom_range(0, 65);
      bcd  = {4'(h/10), 4'(h%10), 4'(m/10), 4'(m%10), 4'(s/10), 4'(s%10)};
      segs = segs_of(bcd);
      if (h < 10 && $urandom_range(0, 1) == 1) segs[41:35] = 7'h00;
      if ($urandom_range(0, 9) == 0) segs[7*$urandom_range(0, 5) +: 7] = bad[$urandom_range(0, 3)];
      skip = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : -1;
      hold = $urandom_range(P + 2, P + 8);
      send_frame(segs, 6'($urandom), hold, 1'($urandom_range(0, 1)) && (hold >= P + 6), skip);
   endtask

   always @(negedge clk) begin
      logic [48:0] e;
      if (rst_n && (o_frame_valid || o_err)) begin
         chk("pulse_exclusive", {63'd0, o_frame_valid & o_err}, 64'd0);
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: actual err=%0b valid=%0b required=no pulse", o_err, o_frame_valid);
         end else begin
            e = sb_q.pop_front();
            chk("frame_event", {15'd0, o_err, o_digits, o_dp, o_sec, o_min, o_hour}, {15'd0, e});
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_state", {14'd0, o_digits, o_dp, o_sec, o_min, o_hour, o_frame_valid, o_err},
          {14'd0, 24'hFFFFFF, 24'd0, 2'b00});

      // 12:34:56
      send_frame(segs_of(24'h123456), 6'b000100, 10, 1'b0, -1);
      chk("s1_digits", {40'd0, o_digits}, 64'h123456);
      chk("s1_sec", {58'd0, o_sec}, 64'd56);
      chk("s1_min", {58'd0, o_min}, 64'd34);
      chk("s1_hour", {58'd0, o_hour}, 64'd12);

      // 08:00:00 with blank hour tens and a glitch in digit 0
      begin
         logic [41:0] sg;
         sg = segs_of(24'h080000);
         sg[41:35] = 7'h00;
         send_frame(sg, 6'd0, 12, 1'b1, -1);
      end
      chk("s2_hour", {58'd0, o_hour}, 64'd8);
      chk("s2_digits", {40'd0, o_digits}, 64'hF80000);

      // invalid pattern on digit 2
      begin
         logic [41:0] sg;
         sg = segs_of(24'h123456);
         sg[20:14] = 7'h01;
         send_frame(sg, 6'd0, 10, 1'b0, -1);
      end
      chk("s3_kept", {40'd0, o_digits}, 64'hF80000);
      send_frame(segs_of(24'h235959), 6'b101010, 10, 1'b0, -1);
      chk("s3_next", {40'd0, o_digits}, 64'h235959);

      // out-of-order scan
      period(0, bcd2seg(4'd0), 1'b0, 10, 1'b0);
      period(1, bcd2seg(4'd1), 1'b0, 10, 1'b0);
      period(3, bcd2seg(4'd3), 1'b0, 10, 1'b0);
      period(4, bcd2seg(4'd4), 1'b0, 10, 1'b0);
      period(5, bcd2seg(4'd5), 1'b0, 10, 1'b0);
      send_frame(segs_of(24'h000000), 6'd0, 10, 1'b0, -1);
      chk("s4_digits", {40'd0, o_digits}, 64'h000000);

      // range errors
      send_frame(segs_of(24'h250000), 6'd0, 10, 1'b0, -1);
      send_frame(segs_of(24'h000060), 6'd0, 10, 1'b0, -1);
      chk("s5_kept", {40'd0, o_digits}, 64'h000000);

      // reset mid-frame
      send_frame(segs_of(24'h111111), 6'd0, 10, 1'b0, -1);
      for (int k = 0; k < 4; k++) period(k, bcd2seg(4'(k)), 1'b1, 10, 1'b0);
      i_seg_enb = 6'h3F;
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset", {14'd0, o_digits, o_dp, o_sec, o_min, o_hour, o_frame_valid, o_err},
          {14'd0, 24'hFFFFFF, 24'd0, 2'b00});
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 3; k < 6; k++) period(k, bcd2seg(4'(k)), 1'b0, 10, 1'b0);
      chk("s6_still_reset", {40'd0, o_digits}, 64'hFFFFFF);
      send_frame(segs_of(24'h012345), 6'b010000, 10, 1'b0, -1);
      chk("s6_frame", {40'd0, o_digits}, 64'h012345);

      for (int n = 0; n < 25; n++) rand_frame();

      repeat (5) @(posedge clk);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
